// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetch port, halfword queue, instruction aligner.
// Define C_EXTENSION_EN for 16-bit instructions and straddle handling.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_WORDS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_insn_valid,
  input  logic        i_insn_ready,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  output logic        o_insn_c
);

  localparam int HW = 2 * QUEUE_WORDS;
  localparam int PW = $clog2(HW);
  localparam int PX = PW + 1;
  localparam int CW = $clog2(HW + 1);

`ifdef C_EXTENSION_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_M = RESET_PC & PC_MASK;
  localparam logic [PX-1:0] HW_X     = PX'(HW);
  localparam logic [CW-1:0] SPACE_MAX = CW'(HW - 2);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_nx;
  logic [31:0]   mem_addr, tgt_addr, pc;
  logic [31:0]   rpc, rword;
  logic          drop;
  logic [15:0]   q [HW];
  logic [PW-1:0] rd_ptr, rd1, wr0, wr1;
  logic [CW-1:0] count, count_nx;
  logic [15:0]   head, nxt;
  logic          head_c, valid, take;
  logic          ack_push, space;
  logic [1:0]    push_n, pop_n;

  function automatic logic [PW-1:0] wrap(input logic [PX-1:0] v);
    return (v >= HW_X) ? PW'(v - HW_X) : PW'(v);
  endfunction

  assign rpc   = i_redirect_pc & PC_MASK;
  assign rword = rpc & WORD_MASK;
  assign rd1   = wrap(PX'(rd_ptr) + PX'(1));
  assign wr0   = wrap(PX'(rd_ptr) + PX'(count));
  assign wr1   = wrap(PX'(wr0) + PX'(1));
  assign head  = q[rd_ptr];
  assign nxt   = q[rd1];

`ifdef C_EXTENSION_EN
  assign head_c = (head[1:0] != 2'b11);
`else
  assign head_c = 1'b0;
`endif

  // Queue occupancy bookkeeping for the coming edge
  always_comb begin
    valid    = head_c ? (count != '0) : (count >= CW'(2));
    take     = valid && i_insn_ready;
    ack_push = (state == REQ) && i_mem_ack && !i_redirect;
    push_n   = 2'd0;
    pop_n    = 2'd0;
    if (ack_push) push_n = drop ? 2'd1 : 2'd2;
    if (take) pop_n = head_c ? 2'd1 : 2'd2;
    if (i_redirect) count_nx = '0;
    else count_nx = count + CW'(push_n) - CW'(pop_n);
    space = (count_nx <= SPACE_MAX);
  end

  // Instruction presentation from registered queue state
  always_comb begin
    o_insn = 32'h0;
    if (valid) o_insn = head_c ? {16'h0, head} : {nxt, head};
    o_insn_valid = valid;
    o_insn_c     = valid && head_c;
    o_insn_pc    = pc;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // FSM next state: one request in flight at most
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (space) state_nx = REQ;
      REQ: begin
        if (i_mem_ack) state_nx = space ? REQ : IDLE;
        else if (i_redirect) state_nx = DRAIN;
      end
      DRAIN: if (i_mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: request follows state, address is registered
  always_comb begin
    o_mem_req  = (state != IDLE);
    o_mem_addr = mem_addr;
  end

  // Fetch address; a redirect during a request parks in tgt_addr
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_addr <= RESET_PC & WORD_MASK;
      tgt_addr <= RESET_PC & WORD_MASK;
    end else begin
      unique case (state)
        IDLE: if (i_redirect) mem_addr <= rword;
        REQ: begin
          if (i_mem_ack)
            mem_addr <= i_redirect ? rword : mem_addr + 32'd4;
          else if (i_redirect)
            tgt_addr <= rword;
        end
        DRAIN: begin
          if (i_mem_ack)
            mem_addr <= i_redirect ? rword : tgt_addr;
          else if (i_redirect)
            tgt_addr <= rword;
        end
        default: ;
      endcase
    end
  end

  // Halfword queue, head PC and drop-low-half flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      count  <= '0;
      pc     <= RESET_PC_M;
      drop   <= RESET_PC_M[1];
      for (int i = 0; i < HW; i++) q[i] <= '0;
    end else begin
      count <= count_nx;
      if (i_redirect) begin
        rd_ptr <= '0;
        pc     <= rpc;
        drop   <= rpc[1];
      end else begin
        rd_ptr <= wrap(PX'(rd_ptr) + PX'(pop_n));
        if (take) pc <= pc + (head_c ? 32'd2 : 32'd4);
        if (ack_push) begin
          drop <= 1'b0;
          if (drop) begin
            q[wr0] <= i_mem_data[31:16];
          end else begin
            q[wr0] <= i_mem_data[15:0];
            q[wr1] <= i_mem_data[31:16];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: scoreboard bench for fetch_aligner.
// Directed vectors; C_EXTENSION_EN selects the matching expectations.
module tb_fetch_aligner;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_insn_valid;
  logic        i_insn_ready;
  logic [31:0] o_insn;
  logic [31:0] o_insn_pc;
  logic        o_insn_c;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  bit   ack_en = 0;
  bit   ready_en = 0;
  int   ack_delay = 0;
  int   ack_cnt = 0;
  int   wcnt = 0;

  fetch_aligner #(.RESET_PC(32'h100), .QUEUE_WORDS(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_insn_valid(o_insn_valid), .i_insn_ready(i_insn_ready),
    .o_insn(o_insn), .o_insn_pc(o_insn_pc), .o_insn_c(o_insn_c)
  );

  initial forever #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  function automatic void exp_push(input logic [31:0] insn,
                                   input logic [31:0] pc, input logic c);
    exp_q.push_back({insn, pc, c});
  endfunction

  // memory model: ack after ack_delay waiting cycles
  initial begin
    i_mem_ack  = 1'b0;
    i_mem_data = 32'h0;
    forever begin
      step();
      i_mem_ack = 1'b0;
      if (!o_mem_req || !i_rst_n) begin
        wcnt = 0;
      end else if (ack_en && wcnt >= ack_delay) begin
        i_mem_ack  = 1'b1;
        i_mem_data = rd(o_mem_addr);
        wcnt = 0;
        ack_cnt++;
      end else begin
        wcnt++;
      end
    end
  end

  // decoder: accept only while something is expected
  initial begin
    i_insn_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_insn_ready = ready_en && (exp_q.size() > 0);
    end
  end

  // monitor: compare every transfer against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_insn_valid && i_insn_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_insn: got %08h at %08h, none expected",
                   o_insn, o_insn_pc);
        end else begin
          e = exp_q.pop_front();
          check("insn", o_insn, e.insn);
          check("insn_pc", o_insn_pc, e.pc);
          check("insn_c", 32'(o_insn_c), 32'(e.c));
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    ready_en = 1'b1;
    while (exp_q.size() > 0 && n < 60) begin
      step();
      n++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    ready_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic redirect(input logic [31:0] a);
    i_redirect    = 1'b1;
    i_redirect_pc = a;
    step();
    i_redirect = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!o_mem_req && n < 20) begin
      step();
      n++;
    end
    check({name, "_req"}, 32'(o_mem_req), 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    int base;
    int held;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    mem[32'h100] = 32'h0050_0093;
    mem[32'h104] = 32'h0010_0113;
    mem[32'h108] = 32'h0020_0193;
    mem[32'h10C] = 32'h0030_0213;
    mem[32'h300] = 32'h0070_0393;
    mem[32'h400] = 32'h4505_0485;
    mem[32'h500] = 32'h4505_0485;
    mem[32'h200] = 32'h0093_0001;
    mem[32'h204] = 32'hAAAA_0050;

    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    #2;
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_addr", o_mem_addr, 32'h100);
    check("rst_valid", 32'(o_insn_valid), 32'd0);
    check("rst_insn", o_insn, 32'h0);
    check("rst_pc", o_insn_pc, 32'h100);
    check("rst_c", 32'(o_insn_c), 32'd0);
    step();
    step();
    ack_en  = 1'b1;
    i_rst_n = 1'b1;

    // first fetch, instruction visible the cycle after ack
    wait_req("first");
    check("first_addr", o_mem_addr, 32'h100);
    step();
    check("first_valid", 32'(o_insn_valid), 32'd1);
    check("first_insn", o_insn, 32'h0050_0093);
    check("first_pc", o_insn_pc, 32'h100);
    check("first_c", 32'(o_insn_c), 32'd0);

    // decoder stalled: outputs frozen, fetch stops at a full queue
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(o_insn_valid && o_insn == 32'h0050_0093 &&
            o_insn_pc == 32'h100 && !o_insn_c)) ok = 1'b0;
    end
    check("stall_frozen", 32'(ok), 32'd1);
    check("full_req", 32'(o_mem_req), 32'd0);
    check("full_acks", 32'(ack_cnt), 32'd2);
    check("full_addr", o_mem_addr, 32'h108);
    exp_push(32'h0050_0093, 32'h100, 1'b0);
    exp_push(32'h0010_0113, 32'h104, 1'b0);
    exp_push(32'h0020_0193, 32'h108, 1'b0);
    exp_push(32'h0030_0213, 32'h10C, 1'b0);
    drain("stream");

    // redirect while a slow request is outstanding
    ack_delay = 3;
    step();
    redirect(32'h108);
    n = 0;
    while (!(o_mem_req && o_mem_addr == 32'h108) && n < 20) begin
      step();
      n++;
    end
    check("slow_req_addr", o_mem_addr, 32'h108);
    redirect(32'h300);
    held = 1;
    ok = 1'b1;
    n = 0;
    while (o_mem_req && n < 20) begin
      if (o_mem_addr != 32'h108 || o_insn_valid) ok = 1'b0;
      held++;
      step();
      n++;
    end
    check("drain_hold", 32'(ok), 32'd1);
    check("drain_cycles", 32'(held), 32'd4);
    n = 0;
    while (!o_mem_req && n < 20) begin
      if (o_insn_valid) ok = 1'b0;
      step();
      n++;
    end
    check("drain_quiet", 32'(ok), 32'd1);
    check("target_addr", o_mem_addr, 32'h300);
    exp_push(32'h0070_0393, 32'h300, 1'b0);
    drain("target");
    ack_delay = 0;

    // PC and fetch address wrap past 2^32
    step();
    redirect(32'hFFFF_FFFC);
    exp_push(32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
    exp_push(32'h0000_0013, 32'h0000_0000, 1'b0);
    drain("wrap");

    // mixed-size word at an odd halfword redirect
    step();
    redirect(32'h402);
`ifdef C_EXTENSION_EN
    exp_push(32'h0000_4505, 32'h402, 1'b1);
`else
    exp_push(32'h4505_0485, 32'h400, 1'b0);
`endif
    drain("word400");
    check("word400_next_pc", o_insn_pc, 32'h404);

`ifdef C_EXTENSION_EN
    // two compressed instructions in one word
    step();
    redirect(32'h500);
    exp_push(32'h0000_0485, 32'h500, 1'b1);
    exp_push(32'h0000_4505, 32'h502, 1'b1);
    drain("rvc_pair");
    check("rvc_next_pc", o_insn_pc, 32'h504);

    // 32-bit instruction straddling two words
    ack_delay = 2;
    step();
    redirect(32'h202);
    n = 0;
    while (!(o_mem_req && o_mem_addr == 32'h200) && n < 20) begin
      step();
      n++;
    end
    base = ack_cnt;
    n = 0;
    while (ack_cnt == base && n < 20) begin
      step();
      n++;
    end
    step();
    check("straddle_early", 32'(o_insn_valid), 32'd0);
    exp_push(32'h0050_0093, 32'h202, 1'b0);
    exp_push(32'h0000_AAAA, 32'h206, 1'b1);
    drain("straddle");
    ack_delay = 0;
`endif

    // reset in the middle of a request
    ack_delay = 3;
    step();
    redirect(32'h600);
    wait_req("pre_reset");
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(o_mem_req), 32'd0);
    check("mid_rst_valid", 32'(o_insn_valid), 32'd0);
    check("mid_rst_addr", o_mem_addr, 32'h100);
    check("mid_rst_pc", o_insn_pc, 32'h100);
    step();
    step();
    ack_delay = 0;
    i_rst_n = 1'b1;
    exp_push(32'h0050_0093, 32'h100, 1'b0);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
